// File: rtl/busio_port_if.sv
// Memory-side bus of busio_port: address, read/write/lock strobes,
// write data with byte parity, read data with byte parity, and acknowledge.
interface busio_port_if;
  logic [19:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_lock;
  logic        mem_ack;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wpar;
  logic [63:0] mem_rdata;
  logic [7:0]  mem_rpar;

  // The port drives the cycle; the memory answers with ack and read data.
  modport master (
    output mem_addr, mem_rd, mem_wr, mem_lock, mem_wdata, mem_wpar,
    input  mem_ack, mem_rdata, mem_rpar
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_lock, mem_wdata, mem_wpar,
    output mem_ack, mem_rdata, mem_rpar
  );
endinterface

// File: rtl/busio_port.sv
// busio_port: CPU-facing register file (ADDR, CMD, RDATA, WDATA) bridging to
// a single-outstanding memory bus with lock, timeout and optional byte parity.
// Optional feature macro: BUSIO_PARITY_EN (odd-count byte parity on mem_wpar,
// read parity checking into par_err). Without it mem_wpar=0 and par_err=0.
module busio_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  arx,
  input  logic        ecx,
  input  logic        wrx,
  input  logic        astb,
  input  logic        rd,
  input  logic        wr,
  input  logic        atomic,
  input  logic [63:0] cpu_din,
  output logic [63:0] cpu_dout,
  output logic        cpu_dout_valid,
  output logic        busy,
  output logic        err,
  output logic        par_err,
  busio_port_if.master mem
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  // Last wait-cycle index before a cycle is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [63:0] rg_q [4];
  logic [63:0] rg_d [4];
  logic [19:0] addr_q, addr_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] dout_q, dout_d;
  logic        dval_q, dval_d;
  logic        err_q, err_d;
  logic        mrd_q, mrd_d;
  logic        mwr_q, mwr_d;
  logic        lock_q, lock_d;
  logic [63:0] wdata_q, wdata_d;

`ifdef BUSIO_PARITY_EN
  logic [7:0]  wpar_q, wpar_d;
  logic [7:0]  rpar_calc;
  logic        perr_q, perr_d;

  // Per-byte parity: a bit is 1 when its byte holds an odd number of ones.
  for (genvar gi = 0; gi < 8; gi++) begin : g_par
    assign wpar_d[gi]    = ^wdata_d[gi*8 +: 8];
    assign rpar_calc[gi] = ^mem.mem_rdata[gi*8 +: 8];
  end
`else
  logic unused_rpar;
  assign unused_rpar = ^mem.mem_rpar;
`endif

  // Next-state: CPU decode first, then the memory-cycle progress, so that
  // returning read data overrides a same-edge register load.
  always_comb begin
    state_d = state_q;
    rg_d    = rg_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dval_d  = 1'b0;
    err_d   = err_q;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    lock_d  = lock_q;
    wdata_d = wdata_q;
`ifdef BUSIO_PARITY_EN
    perr_d  = perr_q;
`endif

    if (ecx) begin
      if (astb) begin
        rg_d[0] = cpu_din;
        addr_d  = cpu_din[19:0];
      end else if (rd || wr) begin
        if (state_q != IDLE) begin
          err_d = 1'b1;
        end else begin
          tgt_d = arx;
          cnt_d = '0;
          if (rd) begin
            state_d = RD_WAIT;
            mrd_d   = 1'b1;
            if (atomic) lock_d = 1'b1;
          end else begin
            state_d = WR_WAIT;
            mwr_d   = 1'b1;
            wdata_d = rg_q[arx];
            if (atomic) wdata_d[55] = 1'b1;
          end
        end
      end else if (wrx) begin
        dout_d = rg_q[arx];
        dval_d = 1'b1;
      end else begin
        rg_d[arx] = cpu_din;
      end
    end

    case (state_q)
      RD_WAIT: begin
        if (mem.mem_ack) begin
          rg_d[tgt_q] = mem.mem_rdata;
          addr_d      = addr_q + 20'd1;
          state_d     = IDLE;
          mrd_d       = 1'b0;
`ifdef BUSIO_PARITY_EN
          if (rpar_calc != mem.mem_rpar) perr_d = 1'b1;
`endif
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = IDLE;
          mrd_d   = 1'b0;
          err_d   = 1'b1;
          lock_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_WAIT: begin
        if (mem.mem_ack) begin
          addr_d  = addr_q + 20'd1;
          state_d = IDLE;
          mwr_d   = 1'b0;
          lock_d  = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = IDLE;
          mwr_d   = 1'b0;
          err_d   = 1'b1;
          lock_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // State register; reset abandons any memory cycle immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) rg_q[i] <= '0;
      addr_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      err_q   <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      lock_q  <= 1'b0;
      wdata_q <= '0;
`ifdef BUSIO_PARITY_EN
      wpar_q  <= '0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rg_q    <= rg_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      err_q   <= err_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      lock_q  <= lock_d;
      wdata_q <= wdata_d;
`ifdef BUSIO_PARITY_EN
      wpar_q  <= wpar_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign cpu_dout       = dout_q;
  assign cpu_dout_valid = dval_q;
  assign busy           = (state_q != IDLE);
  assign err            = err_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_rd     = mrd_q;
  assign mem.mem_wr     = mwr_q;
  assign mem.mem_lock   = lock_q;
  assign mem.mem_wdata  = wdata_q;
`ifdef BUSIO_PARITY_EN
  assign mem.mem_wpar   = wpar_q;
  assign par_err        = perr_q;
`else
  assign mem.mem_wpar   = '0;
  assign par_err        = 1'b0;
`endif

endmodule

// File: doc/busio_port.md
BUSIO_PORT -- requirements
Module: busio_port

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles to wait for mem_ack before aborting a memory cycle (1..255).
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-004 arx  in  2  register select: 0 ADDR (RG0), 1 CMD (RG1), 2 RDATA (RG2), 3 WDATA (RG3).
REQ-005 ecx, wrx, astb, rd, wr, atomic  in  1 each  arbiter control strobes.
REQ-006 cpu_din  in  64  word from CPU; cpu_dout  out  64  word to CPU; cpu_dout_valid  out  1  cpu_dout valid pulse.
REQ-007 busy  out  1  memory cycle in progress; err  out  1  sticky protocol/timeout error; par_err  out  1  sticky parity error.
REQ-008 mem_addr  out  20  word address; mem_rd, mem_wr, mem_lock  out  1 each; mem_ack  in  1  memory acknowledge.
REQ-009 mem_wdata  out  64; mem_wpar  out  8; mem_rdata  in  64; mem_rpar  in  8.

Function
REQ-010 Decode, evaluated each cycle with ecx=1: astb -> ADDR load; rd -> memory read; wr -> memory write; wrx -> CPU read; otherwise -> register load.
REQ-011 ADDR load (astb=1): RG0 <= cpu_din and the address counter <= cpu_din[19:0] on the same edge.
REQ-012 Register load: RG[arx] <= cpu_din.
REQ-013 CPU read: cpu_dout <= RG[arx] and cpu_dout_valid=1 on the next cycle only.
REQ-014 FSM states are IDLE, RD_WAIT and WR_WAIT; busy=1 in both WAIT states.
REQ-015 From IDLE, rd -> RD_WAIT and wr -> WR_WAIT, with the target index arx latched; mem_rd or mem_wr rises on the next cycle.
REQ-016 mem_rd, mem_wr and mem_addr (= address counter) stay stable through a WAIT state until mem_ack is sampled high.
REQ-017 mem_ack in RD_WAIT: RG[target] <= mem_rdata, address counter +1 modulo 2^20, return to IDLE; busy falls on the following cycle.
REQ-018 mem_ack in WR_WAIT: address counter +1 modulo 2^20, return to IDLE.
REQ-019 mem_wdata = RG[target] captured when wr is accepted; if atomic=1 at acceptance, bit 55 is forced to 1.
REQ-020 mem_lock rises with an accepted rd that has atomic=1 and falls after mem_ack of the next write or on timeout.
REQ-021 An rd or wr while busy=1 is ignored and sets err.
REQ-022 Register loads and CPU reads remain legal while busy=1.
REQ-023 If a register load and read data target the same register on the same edge, mem_rdata wins.
REQ-024 A cycle counter counts cycles spent in a WAIT state; reaching TIMEOUT without mem_ack returns to IDLE, sets err, leaves registers unchanged and does not increment the address.
REQ-025 mem_ack while in IDLE is ignored.
REQ-026 With ecx=0, all other control inputs are ignored.

Reset
REQ-027 reset=0 clears RG0..RG3, the address counter, cpu_dout, cpu_dout_valid, busy, err, par_err, mem_rd, mem_wr, mem_lock, mem_wdata and mem_wpar to 0, and sets the FSM to IDLE.
REQ-028 Reset mid-cycle abandons the memory cycle at once: mem_rd/mem_wr are low on the next cycle and a later mem_ack has no effect.

Configuration
REQ-029 With BUSIO_PARITY_EN defined, mem_wpar[i] is odd parity of mem_wdata byte i.
REQ-030 With BUSIO_PARITY_EN defined, on read mem_ack the parity of mem_rdata bytes is checked against mem_rpar; a mismatch sets par_err, and the data is still loaded.
REQ-031 Without BUSIO_PARITY_EN, all ports are still present, mem_wpar=0, mem_rpar is ignored and par_err=0.

Verification
REQ-032 astb with cpu_din=0x12345, then rd arx=2, mem_ack after 3 cycles with mem_rdata=0xAA -> mem_addr=0x12345, RG2=0xAA, next mem_addr=0x12346; a CPU read then gives cpu_dout=0xAA.
REQ-033 Load RG3=0x1, atomic rd, then atomic wr arx=2 with RG2=0 -> mem_lock high across both cycles, mem_wdata=0x0080_0000_0000_0000.
REQ-034 Address counter 0xFFFFF, two back-to-back read acks -> mem_addr 0xFFFFF then 0x00000.
REQ-035 No mem_ack with TIMEOUT=4 -> returns to IDLE after 4 WAIT cycles, err=1, address unchanged; a second rd during busy also sets err.
REQ-036 BUSIO_PARITY_EN defined, read with mem_rdata=0x01 and mem_rpar=0xFF -> par_err=1; without the macro, same stimulus -> par_err=0.
REQ-037 reset=0 asserted during RD_WAIT, then mem_ack -> all outputs 0 and RG2 unchanged at 0.
